// File: rtl/ahb_defs.sv
// ahb_defs: shared AHB-Lite transfer/size/response codes, the data-phase
// state encoding of ahb_sram_ctrl and a byte-enable to bit-mask helper.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [2:0] {
    DP_IDLE  = 3'd0,
    DP_READ  = 3'd1,
    DP_WRITE = 3'd2,
    DP_ERR1  = 3'd3,
    DP_ERR2  = 3'd4
  } dp_state_e;

  // Expand a 4-bit byte enable into a 32-bit data mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ahb_lane_dec.sv
// ahb_lane_dec: maps transfer size and the low address bits to SRAM byte
// enables and flags accesses that are not naturally aligned.
module ahb_lane_dec
  import ahb_defs::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misaligned_o
);

  // Byte-lane selection; address bits below the access size are ignored.
  always_comb begin
    be_o         = 4'b1111;
    misaligned_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: begin
        be_o         = 4'b0001 << addr_lo_i;
        misaligned_o = 1'b0;
      end
      HSIZE_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave in front of a single-port synchronous SRAM.
// Zero-wait reads, writes posted through a one-entry write buffer (WB) with
// read-after-write forwarding; one wait state only on a port conflict.
// Optional feature macro: AHB_SRAM_RANGE_CHK_EN (window and alignment checks
// with a two-cycle ERROR response).
module ahb_sram_ctrl
  import ahb_defs::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [33:0] BASE_ADDR = 34'h0_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [33:0]       haddr,
  input  logic              hwrite,
  input  logic [1:0]        hsize,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  dp_state_e         dp_q, dp_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_be_q, wr_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]        wb_be_q, wb_be_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [3:0]        fwd_be_q, fwd_be_d;
  logic [31:0]       fwd_data_q, fwd_data_d;

  logic [ADDR_W-1:0] addr_word_s;
  logic [3:0]        lane_be_s;
  logic [31:0]       fwd_mask_s;
  logic              misaligned_s, err_s, accept_s, rd_accept_s, wr_accept_s;
  logic              wait_s, drain_s, wb_fill_s;

  assign addr_word_s = haddr[ADDR_W+1:2];
  assign fwd_mask_s  = be_to_mask(fwd_be_q);

  ahb_lane_dec u_lane_dec (
    .size_i       (hsize),
    .addr_lo_i    (haddr[1:0]),
    .be_o         (lane_be_s),
    .misaligned_o (misaligned_s)
  );

`ifdef AHB_SRAM_RANGE_CHK_EN
  localparam logic [34:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [34:0] WIN_HI = WIN_LO + (35'd4 << ADDR_W);
  logic [34:0] haddr_ext_s;
  logic        unused_ok;
  assign haddr_ext_s = {1'b0, haddr};
  assign err_s       = (haddr_ext_s < WIN_LO) | (haddr_ext_s >= WIN_HI) | misaligned_s;
  assign unused_ok   = ^{hburst, hprot, hmastlock};
`else
  // Upper address bits alias; no error responses are ever produced.
  logic unused_ok;
  assign err_s     = 1'b0;
  assign unused_ok = ^{hburst, hprot, hmastlock, haddr[33:ADDR_W+2], misaligned_s, BASE_ADDR};
`endif

  // The controller is held quiet while reset is asserted.
  assign accept_s    = hsel & hready & htrans[1] & ~rst;
  assign rd_accept_s = accept_s & ~hwrite & ~err_s;
  assign wr_accept_s = accept_s & hwrite & ~err_s;
  // Stall is derived without hready so the bus has no combinational loop.
  assign wait_s      = (dp_q == DP_WRITE) & wb_valid_q & hsel & htrans[1] & ~hwrite;
  // A read owns the port; the WB drains on any other cycle.
  assign drain_s     = wb_valid_q & ~rd_accept_s & ~rst;
  assign wb_fill_s   = (dp_q == DP_WRITE) & ~wait_s;

  // Bus handshake and response driven from the data-phase state.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (dp_q)
      DP_WRITE: hreadyout = ~wait_s;
      DP_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERR;
      end
      DP_ERR2: begin
        hreadyout = 1'b1;
        hresp     = RESP_ERR;
      end
      default: begin
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;
      end
    endcase
  end

  // Read data: SRAM word with forwarded bytes from a not-yet-written store merged in.
  always_comb begin
    if (dp_q == DP_READ) begin
      hrdata = (sram_rdata & ~fwd_mask_s) | (fwd_data_q & fwd_mask_s);
    end else begin
      hrdata = 32'h0;
    end
  end

  // SRAM port arbitration: accepted read first, otherwise WB drain.
  always_comb begin
    sram_wdata = wb_data_q;
    if (rd_accept_s) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b0;
      sram_addr = addr_word_s;
      sram_be   = lane_be_s;
    end else if (drain_s) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = wb_addr_q;
      sram_be   = wb_be_q;
    end else begin
      sram_cs   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = wb_addr_q;
      sram_be   = 4'b0000;
    end
  end

  // Next-state computation for the data-phase FSM, write latch, WB and forward path.
  always_comb begin
    dp_d       = dp_q;
    wr_addr_d  = wr_addr_q;
    wr_be_d    = wr_be_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_be_d    = wb_be_q;
    wb_data_d  = wb_data_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;

    if (dp_q == DP_ERR1) begin
      dp_d = DP_ERR2;
    end else if (wait_s) begin
      dp_d = DP_WRITE;
    end else if (accept_s) begin
      if (err_s) begin
        dp_d = DP_ERR1;
      end else if (hwrite) begin
        dp_d = DP_WRITE;
      end else begin
        dp_d = DP_READ;
      end
    end else begin
      dp_d = DP_IDLE;
    end

    if (wr_accept_s) begin
      wr_addr_d = addr_word_s;
      wr_be_d   = lane_be_s;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_be_d   = wr_be_q;
    end

    // Youngest store wins: the write in its data phase, then the WB.
    if (rd_accept_s) begin
      if ((dp_q == DP_WRITE) && (wr_addr_q == addr_word_s)) begin
        fwd_be_d   = wr_be_q;
        fwd_data_d = hwdata;
      end else if (wb_valid_q && (wb_addr_q == addr_word_s)) begin
        fwd_be_d   = wb_be_q;
        fwd_data_d = wb_data_q;
      end else begin
        fwd_be_d   = 4'b0000;
        fwd_data_d = 32'h0;
      end
    end else begin
      fwd_be_d   = fwd_be_q;
      fwd_data_d = fwd_data_q;
    end

    // Refill only into an empty or simultaneously draining buffer.
    if (wb_fill_s && (!wb_valid_q || drain_s)) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = wr_addr_q;
      wb_be_d    = wr_be_q;
      wb_data_d  = hwdata;
    end else if (drain_s) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // State registers; reset drops any pending buffered write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q       <= DP_IDLE;
      wr_addr_q  <= '0;
      wr_be_q    <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_be_q    <= 4'b0000;
      wb_data_q  <= 32'h0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      dp_q       <= dp_d;
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_be_q    <= wb_be_d;
      wb_data_q  <= wb_data_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed plus randomized AHB traffic against ahb_sram_ctrl,
// checked against an architectural memory image (every store applied in bus
// order, every load expecting the current image word).
module tb_ahb_sram_ctrl;
  import ahb_defs::*;

  localparam int DEPTH = 16384;

  logic        clk, rst;
  logic        hsel, hwrite, hmastlock, hready;
  logic [33:0] haddr;
  logic [1:0]  hsize, htrans;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic        sram_cs, sram_we;
  logic [3:0]  sram_be;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic        mem_init, bd_we;
  logic [13:0] bd_addr;
  logic [31:0] bd_data;
  logic [31:0] sram_mem [0:DEPTH-1];
  logic [31:0] golden   [0:DEPTH-1];

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic        dp_valid, dp_write;
  logic [31:0] dp_wdata, dp_exp, last_rdata;

  assign hready = hreadyout;

  ahb_sram_ctrl dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hburst(hburst), .hprot(hprot),
    .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1357_2468;
  endfunction

  // Behavioural single-port synchronous SRAM with a backdoor preload port
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
      sram_rdata <= 32'h0;
    end else begin
      if (bd_we) begin
        sram_mem[bd_addr] <= bd_data;
      end else if (sram_cs && sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      if (sram_cs && !sram_we) sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [33:0] a);
    return int'(a[15:2]);
  endfunction

  // Architectural store: bytes covered by the access, located by plain arithmetic
  task automatic apply_write(input logic [33:0] a, input logic [1:0] sz, input logic [31:0] d);
    int nb, first, w;
    nb    = 1 << sz;
    first = (int'(a[1:0]) / nb) * nb;
    w     = widx(a);
    for (int i = first; i < first + nb; i++) golden[w][8*i +: 8] = d[8*i +: 8];
  endtask

  // One AHB address phase (held through wait states) plus the previous data phase
  task automatic ahb_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [1:0] size, input logic [33:0] addr,
                           input logic [31:0] wdata, output int stalls);
    stalls = 0;
    @(posedge clk); #1;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr;
    hwdata = dp_write ? dp_wdata : 32'h0;
    @(negedge clk);
    while (!hreadyout && stalls < 4) begin
      stalls++;
      @(negedge clk);
    end
    if (!hreadyout) check_eq("stall_bound", 32'(hreadyout), 32'd1);
    if (dp_valid && !dp_write) begin
      check_eq("rdata", hrdata, dp_exp);
      last_rdata = hrdata;
    end
    check_eq("hresp", 32'(hresp), 32'd0);
    if (sel && trans[1]) begin
      dp_valid = 1'b1;
      dp_write = wr;
      dp_wdata = wdata;
      if (wr) apply_write(addr, size, wdata);
      else dp_exp = golden[widx(addr)];
    end else begin
      dp_valid = 1'b0;
      dp_write = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    int st;
    for (int i = 0; i < n; i++) ahb_cycle(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 34'h0, 32'h0, st);
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(posedge clk); #1;
    bd_addr = 14'(w); bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    golden[w] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, s1, s2, s3;
    logic [33:0] a;
    logic [1:0]  sz;
    int          w, off;

    for (int i = 0; i < DEPTH; i++) golden[i] = init_word(i);
    rst = 1'b1; mem_init = 1'b1; bd_we = 1'b0; bd_addr = 14'h0; bd_data = 32'h0;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 34'h0;
    hburst = 3'b000; hprot = 4'b0000; hmastlock = 1'b0; hwdata = 32'h0;
    dp_valid = 1'b0; dp_write = 1'b0; dp_wdata = 32'h0; dp_exp = 32'h0; last_rdata = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp", 32'(hresp), 32'd0);
    check_eq("rst_hrdata", hrdata, 32'h0);
    check_eq("rst_sram_cs", 32'(sram_cs), 32'd0);
    check_eq("rst_sram_we", 32'(sram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;
    idle(2);

    // 1: plain zero-wait read
    preload(4, 32'hDEAD_BEEF);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0010, 32'h0, s1);
    idle(1);
    check_eq("t1_rdata", last_rdata, 32'hDEAD_BEEF);
    check_eq("t1_wait", 32'(s1), 32'd0);

    // 2: byte store forwarded into a back-to-back word load
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 34'h0_8000_0011, 32'hA5A5_A5A5, s1);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0010, 32'h0, s2);
    idle(1);
    check_eq("t2_fwd", last_rdata, 32'hDEAD_A5EF);
    check_eq("t2_wait", 32'(s1 + s2), 32'd0);

    // 3: SW, SW, LW -> exactly one wait state, in the 2nd store's data phase
    idle(2);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 34'h0_8000_0040, 32'h1111_2222, s1);
    ahb_cycle(1'b1, HTRANS_SEQ,    1'b1, HSIZE_WORD, 34'h0_8000_0044, 32'h3333_4444, s2);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0048, 32'h0, s3);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0040, 32'h0, st);
    check_eq("t3_wait_sw1", 32'(s1), 32'd0);
    check_eq("t3_wait_sw2", 32'(s2), 32'd0);
    check_eq("t3_wait_lw", 32'(s3), 32'd1);
    check_eq("t3_wait_after", 32'(st), 32'd0);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0044, 32'h0, st);
    idle(1);
    check_eq("t3_sw2_data", last_rdata, 32'h3333_4444);

    // 6: halfword store framed by BUSY and deselected cycles
    idle(2);
    preload(0, 32'h1122_3344);
    ahb_cycle(1'b1, HTRANS_BUSY,   1'b1, HSIZE_WORD, 34'h0_8000_0000, 32'h0, st);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 34'h0_8000_0002, 32'hCAFE_BABE, st);
    ahb_cycle(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 34'h0_8000_0000, 32'h0, st);
    ahb_cycle(1'b1, HTRANS_BUSY,   1'b0, HSIZE_WORD, 34'h0_8000_0000, 32'h0, st);
    idle(3);
    check_eq("t6_sram_word", sram_mem[0], 32'hCAFE_3344);

    // 5: access outside the window / aliasing
`ifdef AHB_SRAM_RANGE_CHK_EN
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 34'h0;
    #1 check_eq("t5_no_cs", 32'(sram_cs), 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check_eq("t5_err1_ready", 32'(hreadyout), 32'd0);
    check_eq("t5_err1_resp", 32'(hresp), 32'd1);
    check_eq("t5_err1_cs", 32'(sram_cs), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_err2_ready", 32'(hreadyout), 32'd1);
    check_eq("t5_err2_resp", 32'(hresp), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_after_resp", 32'(hresp), 32'd0);
    dp_valid = 1'b0; dp_write = 1'b0;
`else
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0, 32'h0, st);
    idle(1);
    check_eq("t5_alias", last_rdata, 32'hCAFE_3344);
`endif

    // 4: reset while the WB holds a store; the store must be lost
    idle(2);
    preload(32, 32'h5555_AAAA);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 34'h0_8000_0080, 32'h1234_5678, st);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0084, 32'h0, st);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 34'h0_8000_0084; hwdata = 32'h0;
    #2;
    check_eq("t4_read_prio", {30'd0, sram_cs, sram_we}, 32'd2);
    rst = 1'b1;
    #1;
    check_eq("t4_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("t4_hresp", 32'(hresp), 32'd0);
    check_eq("t4_hrdata", hrdata, 32'h0);
    check_eq("t4_sram_cs", 32'(sram_cs), 32'd0);
    check_eq("t4_sram_we", 32'(sram_we), 32'd0);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    rst = 1'b0;
    dp_valid = 1'b0; dp_write = 1'b0;
    golden[32] = 32'h5555_AAAA;
    idle(3);
    check_eq("t4_sram_kept", sram_mem[32], 32'h5555_AAAA);
    ahb_cycle(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 34'h0_8000_0080, 32'h0, st);
    idle(1);
    check_eq("t4_read_back", last_rdata, 32'h5555_AAAA);

    // random mixed traffic over a few hot words
    for (int n = 0; n < 400; n++) begin
      w   = $urandom_range(0, 7);
      sz  = 2'($urandom_range(0, 2));
      off = $urandom_range(0, 3) & ~((1 << sz) - 1);
      a   = 34'h0_8000_0000 + 34'(w * 4 + off);
      if ($urandom_range(0, 9) < 2) begin
        if ($urandom_range(0, 1) == 1)
          ahb_cycle(1'b1, HTRANS_BUSY, 1'($urandom_range(0, 1)), sz, a, $urandom, st);
        else
          ahb_cycle(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sz, a, $urandom, st);
      end else begin
        ahb_cycle(1'b1, ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ,
                  1'($urandom_range(0, 1)), sz, a, $urandom, st);
      end
      if (st > 1) check_eq("max_one_wait", 32'(st), 32'd1);
    end
    idle(3);
    for (int i = 0; i < 8; i++) check_eq("final_mem", sram_mem[i], golden[i]);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
